// File: rtl/udlx_pkg.sv
// Shared UDLX core definitions: datapath widths, NOP encoding and the
// fetch-unit state encoding.
package udlx_pkg;

   localparam int UDLX_PC_WIDTH   = 20;
   localparam int UDLX_DATA_WIDTH = 32;

   // All-zero word decodes as a no-operation.
   localparam logic [UDLX_DATA_WIDTH-1:0] UDLX_NOP = '0;

   // FETCH: issue or hold a request whose data will be used.
   // DISCARD: an old request is still outstanding after a redirect; its data is dropped.
   typedef enum logic {
      ST_FETCH   = 1'b0,
      ST_DISCARD = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/fetch_out_reg.sv
// Valid/stall output register between fetch and decode. It holds the
// presented instruction while decode stalls and drops it when consumed
// or flushed.
module fetch_out_reg
   import udlx_pkg::*;
#(
   parameter int PC_WIDTH   = UDLX_PC_WIDTH,
   parameter int DATA_WIDTH = UDLX_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  load,
   input  logic                  consume,
   input  logic [DATA_WIDTH-1:0] load_inst,
   input  logic [PC_WIDTH-1:0]   load_pc,
   output logic                  valid,
   output logic [DATA_WIDTH-1:0] inst,
   output logic [PC_WIDTH-1:0]   pc
);

   // Flush beats a new load; a consumed entry without a replacement goes empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         inst  <= DATA_WIDTH'(UDLX_NOP);
         pc    <= '0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         inst  <= load_inst;
         pc    <= load_pc;
      end else if (consume) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch unit. It keeps the fetch PC, runs the request/ack
// handshake with instruction memory, handles redirects (including
// dropping an in-flight read) and feeds the decode-facing output register.
module pc_fetch_unit
   import udlx_pkg::*;
#(
   parameter int                   PC_WIDTH       = UDLX_PC_WIDTH,
   parameter int                   DATA_WIDTH     = UDLX_DATA_WIDTH,
   parameter logic [PC_WIDTH-1:0]  PC_RESET_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  select_new_pc_in,
   input  logic [PC_WIDTH-1:0]   new_pc_in,
   input  logic                  stall_in,
   output logic                  imem_req_out,
   output logic [PC_WIDTH-1:0]   imem_addr_out,
   input  logic                  imem_ack_in,
   input  logic [DATA_WIDTH-1:0] imem_data_in,
   output logic                  inst_valid_out,
   output logic [DATA_WIDTH-1:0] inst_out,
   output logic [PC_WIDTH-1:0]   pc_out
);

   localparam logic [PC_WIDTH-1:0] WORD_MASK = ~PC_WIDTH'(3);
   localparam logic [PC_WIDTH-1:0] WORD_STEP = PC_WIDTH'(4);

   fetch_state_t        state, state_nxt;
   logic [PC_WIDTH-1:0] fpc, fpc_nxt;
   logic [PC_WIDTH-1:0] fetch_addr;
   logic [PC_WIDTH-1:0] req_addr;
   logic                pend, pend_nxt;
   logic                complete;
   logic                load_out;
   logic                flush_out;

   assign fetch_addr = fpc & WORD_MASK;

   // Request/address: an outstanding request is held unchanged until its ack;
   // a new one starts only when the output slot frees up and no redirect is present.
   always_comb begin
      imem_req_out  = 1'b0;
      imem_addr_out = fetch_addr;
      if (pend) begin
         imem_addr_out = req_addr;
      end
      if (rst) begin
         imem_req_out = 1'b0;
      end else if (state == ST_DISCARD || pend) begin
         imem_req_out = 1'b1;
      end else begin
         imem_req_out = (!inst_valid_out || !stall_in) && !select_new_pc_in;
      end
   end

   assign complete = imem_req_out && imem_ack_in;

   // Next state, next fetch PC and output-register commands.
   always_comb begin
      state_nxt = state;
      fpc_nxt   = fpc;
      pend_nxt  = imem_req_out && !imem_ack_in;
      load_out  = 1'b0;
      flush_out = 1'b0;
      case (state)
         ST_FETCH: begin
            if (select_new_pc_in) begin
               fpc_nxt   = new_pc_in & WORD_MASK;
               flush_out = 1'b1;
               if (imem_req_out && !imem_ack_in) begin
                  state_nxt = ST_DISCARD;
               end
            end else if (complete) begin
               load_out = 1'b1;
               fpc_nxt  = fpc + WORD_STEP;
            end
         end
         ST_DISCARD: begin
            if (select_new_pc_in) begin
               fpc_nxt   = new_pc_in & WORD_MASK;
               flush_out = 1'b1;
            end
            if (imem_ack_in) begin
               state_nxt = ST_FETCH;
            end
         end
         default: begin
            state_nxt = ST_FETCH;
         end
      endcase
   end

   // Control state: FSM, fetch PC and outstanding-request flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_FETCH;
         fpc   <= PC_RESET_VALUE;
         pend  <= 1'b0;
      end else begin
         state <= state_nxt;
         fpc   <= fpc_nxt;
         pend  <= pend_nxt;
      end
   end

   // Capture the address of a newly issued request so it stays stable until acked.
   always_ff @(posedge clk) begin
      if (imem_req_out && !pend) begin
         req_addr <= fetch_addr;
      end
   end

   fetch_out_reg #(
      .PC_WIDTH   (PC_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_out_reg (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush_out),
      .load      (load_out),
      .consume   (!stall_in),
      .load_inst (imem_data_in),
      .load_pc   (imem_addr_out),
      .valid     (inst_valid_out),
      .inst      (inst_out),
      .pc        (pc_out)
   );

endmodule
